decoder_code_sequencer: RTL

- Synchronous source of the 3-bit select code that drives the 3-to-8 decoder stage.
- Replaces the ripple-clocked flip-flop divider chain with a single-clock design: a prescaler produces a step enable, and a 3-bit up/down counter advances on each step.
- Also outputs a registered one-hot copy of the code and a wrap pulse, so the downstream display logic can run without the decoder when needed.

---
 rtl/decoder_code_sequencer.sv | 88 ++++++++
 1 files changed

// File: rtl/decoder_code_sequencer.sv
// decoder_code_sequencer
// Single-clock source of the 3-bit select code for the 3-to-8 decoder stage.
// A prescaler turns DIV enabled clocks into one step; each step moves the
// code up or down by one (mod 8). A registered one-hot copy of the code and
// a wrap pulse are provided alongside, all aligned to the same clock edge.
module decoder_code_sequencer #(
    parameter int DIV        = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       step_tick,
    output logic [2:0] code,
    output logic [7:0] onehot,
    output logic       wrap
);

    // Terminal prescaler value; a step fires when an enabled cycle sees it.
    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(DIV - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [2:0]            code_q, code_d;
    logic [7:0]            onehot_q, onehot_d;
    logic                  step_tick_q, step_tick_d;
    logic                  wrap_q, wrap_d;
    logic                  step;

    // Next-state: load beats step beats hold; pulses default low every cycle.
    always_comb begin
        step        = en && (presc_q == PRESC_LAST);
        presc_d     = presc_q;
        code_d      = code_q;
        step_tick_d = 1'b0;
        wrap_d      = 1'b0;
        if (load) begin
            // A coincident step is deliberately dropped and the window restarts.
            code_d  = load_val;
            presc_d = '0;
        end else if (step) begin
            presc_d     = '0;
            step_tick_d = 1'b1;
            if (dir) begin
                code_d = code_q - 3'd1;
                wrap_d = (code_q == 3'd0);
            end else begin
                code_d = code_q + 3'd1;
                wrap_d = (code_q == 3'd7);
            end
        end else if (en) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // One-hot is decoded from the next code so it registers on the same edge.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign onehot_d[gi] = (code_d == 3'(gi));
        end
    endgenerate

    // State register; reset discards any partial prescale window.
    always_ff @(posedge clkin) begin
        if (rst) begin
            presc_q     <= '0;
            code_q      <= 3'd0;
            onehot_q    <= 8'h01;
            step_tick_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            code_q      <= code_d;
            onehot_q    <= onehot_d;
            step_tick_q <= step_tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign code      = code_q;
    assign onehot    = onehot_q;
    assign step_tick = step_tick_q;
    assign wrap      = wrap_q;

endmodule
